iagu_conv_gsched: RTL and testbench
===================================

IAGU_CONV_GSCHED -- requirements
Module: iagu_conv_gsched

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, width of all address/column buses.
REQ-002 SHALL have parameter PE_COLS, default 7, PE columns per part.
REQ-003 SHALL have ports:
- i_clk, input, 1, sole clock.
- i_rst, input, 1, synchronous active-high reset.
- i_AGUStart, input, 1, one-cycle job start.
- i_BaseAddr, input, ADDR_W, IOB address of job row 0, padded column 0.
- i_RowPitch, input, ADDR_W, address step per row.
- i_RowNum, input, 8, rows in job.
- i_Output_XLength, input, 8, output columns per row.
- i_KerCol, input, 4, kernel columns.
- i_Stride, input, 2, column stride.
- i_Pad, input, 2, left pad.
- i_FifoReady, input, 1, downstream PE FIFO can accept one group.
- i_GroupLoadEnd, input, 1, AGU group done (level).
- i_AGU_Endf, input, 1, AGU job end flag.
- o_AGUStart, output, 1, registered start pulse to AGU.
- o_GroupStart, output, 1, one-cycle group launch.
- o_BaseAdder, output, ADDR_W, group base address.
- o_InputCurCol, output, ADDR_W, padded input column of PE column 0.
- o_PartFlag, output, 2, bit1 first part, bit0 last part.
- o_LastColNum, output, 3, length of last part (1..7).
- o_BaseAdderEndf, output, 1, last group issued.
- o_Busy, output, 1, job in progress.
- o_Done, output, 1, one-cycle job completion.

Function
REQ-004 SHALL implement FSM IDLE, ISSUE, WAIT, DRAIN; all outputs registered.
REQ-005 IDLE: i_AGUStart latches all config, asserts o_AGUStart next cycle, enters ISSUE; i_AGUStart outside IDLE ignored.
REQ-006 Parts = ceil(i_Output_XLength/7); o_LastColNum = i_Output_XLength - 7*(Parts-1), computed at start, held through job.
REQ-007 Loop order: row r outer, part p middle, kernel column k inner; one group per (r,p,k).
REQ-008 o_InputCurCol = p*7*i_Stride + k; o_BaseAdder = i_BaseAddr + r*i_RowPitch + o_InputCurCol - i_Pad, modulo 2^ADDR_W; computed by incremental accumulators, no multipliers.
REQ-009 o_PartFlag[1] = (p==0); o_PartFlag[0] = (p==Parts-1); both set when Parts==1.
REQ-010 ISSUE: when i_FifoReady and i_GroupLoadEnd both high, pulse o_GroupStart one cycle with the group's fields valid that cycle, go WAIT; otherwise hold.
REQ-011 First o_GroupStart no earlier than 2 cycles after accepted i_AGUStart.
REQ-012 WAIT: the cycle after o_GroupStart is never counted; from then, i_GroupLoadEnd high advances indices and returns to ISSUE, or to DRAIN after the last group.
REQ-013 o_BaseAdderEndf rises with the last group's o_GroupStart and holds until return to IDLE.
REQ-014 DRAIN: when i_AGU_Endf high, pulse o_Done, clear o_BaseAdderEndf, go IDLE.
REQ-015 Degenerate job (i_RowNum, i_Output_XLength or i_KerCol zero): no o_GroupStart; o_AGUStart, then o_Done 2 cycles after start.
REQ-016 o_Busy high from cycle after accepted start through o_Done cycle inclusive.
REQ-017 Field outputs hold last value between groups.

Reset
REQ-018 i_rst at any cycle, including mid-job, returns FSM to IDLE next edge; all outputs 0 except o_LastColNum = 7; in-flight group abandoned, no o_Done.

Configuration
REQ-019 Macro IAGU_GSCHED_PERF_EN, when defined, adds outputs o_GroupCnt (20 bits, groups issued this job) and o_StallCnt (16 bits, ISSUE cycles with i_FifoReady low, saturating); both cleared on accepted start and on reset.
REQ-020 Without IAGU_GSCHED_PERF_EN, those ports and counters are absent; all other behaviour identical.

Verification
REQ-021 XLen=14, KerCol=3, Rows=1, Stride=1, Pad=1, Base=0x100, ready always -> 6 groups; InputCurCol 0,1,2,7,8,9; BaseAdder 0x0FF,0x100,0x101,0x106,0x107,0x108; PartFlag 10,10,10,01,01,01; LastColNum=7.
REQ-022 XLen=5, KerCol=1, Stride=2, Rows=2, RowPitch=0x20 -> 2 groups, PartFlag 11 both, LastColNum=5, BaseAdder Base-Pad then Base-Pad+0x20.
REQ-023 i_FifoReady low 10 cycles in ISSUE -> no o_GroupStart until ready; with PERF_EN o_StallCnt=10.
REQ-024 XLen=0 -> o_AGUStart cycle 1, o_Done cycle 2, no o_GroupStart.
REQ-025 i_rst asserted after 3rd group -> outputs reset next cycle; new start reissues from group 0.
REQ-026 i_AGUStart pulsed during WAIT -> ignored; group sequence and o_Done unchanged.

Source files
------------

// File: rtl/iagu_conv_gsched_if.sv
// Job, AGU and PE-FIFO signal bundle for the convolution group scheduler.
// Perf counter outputs exist only when IAGU_GSCHED_PERF_EN is defined.
interface iagu_conv_gsched_if #(
   parameter int ADDR_W = 12
);
   logic              i_AGUStart;
   logic [ADDR_W-1:0] i_BaseAddr;
   logic [ADDR_W-1:0] i_RowPitch;
   logic [7:0]        i_RowNum;
   logic [7:0]        i_Output_XLength;
   logic [3:0]        i_KerCol;
   logic [1:0]        i_Stride;
   logic [1:0]        i_Pad;
   logic              i_FifoReady;
   logic              i_GroupLoadEnd;
   logic              i_AGU_Endf;

   logic              o_AGUStart;
   logic              o_GroupStart;
   logic [ADDR_W-1:0] o_BaseAdder;
   logic [ADDR_W-1:0] o_InputCurCol;
   logic [1:0]        o_PartFlag;
   logic [2:0]        o_LastColNum;
   logic              o_BaseAdderEndf;
   logic              o_Busy;
   logic              o_Done;
`ifdef IAGU_GSCHED_PERF_EN
   logic [19:0]       o_GroupCnt;
   logic [15:0]       o_StallCnt;
`endif

   modport slave (
      input  i_AGUStart, i_BaseAddr, i_RowPitch, i_RowNum, i_Output_XLength,
             i_KerCol, i_Stride, i_Pad, i_FifoReady, i_GroupLoadEnd, i_AGU_Endf,
      output o_AGUStart, o_GroupStart, o_BaseAdder, o_InputCurCol, o_PartFlag,
             o_LastColNum, o_BaseAdderEndf, o_Busy, o_Done
`ifdef IAGU_GSCHED_PERF_EN
      , output o_GroupCnt, o_StallCnt
`endif
   );

   modport master (
      output i_AGUStart, i_BaseAddr, i_RowPitch, i_RowNum, i_Output_XLength,
             i_KerCol, i_Stride, i_Pad, i_FifoReady, i_GroupLoadEnd, i_AGU_Endf,
      input  o_AGUStart, o_GroupStart, o_BaseAdder, o_InputCurCol, o_PartFlag,
             o_LastColNum, o_BaseAdderEndf, o_Busy, o_Done
`ifdef IAGU_GSCHED_PERF_EN
      , input o_GroupCnt, o_StallCnt
`endif
   );
endinterface

// File: rtl/iagu_conv_gsched.sv
// Convolution group scheduler: walks row/part/kernel-column groups and launches them to the AGU.
// Define IAGU_GSCHED_PERF_EN to add group and stall counters.
//
// state | meaning
// IDLE  | waiting for a job start; config latched on start
// ISSUE | launching the current group once the FIFO is ready and the AGU is idle
// WAIT  | group in flight; AGU done level ignored for two cycles after launch
// DRAIN | last group launched; waiting for the AGU job end flag
module iagu_conv_gsched #(
   parameter int ADDR_W  = 12,
   parameter int PE_COLS = 7
) (
   input logic               i_clk,
   input logic               i_rst,
   iagu_conv_gsched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
   state_t state, stateNext;

   logic [ADDR_W-1:0] rowPitch, rowBase, partCol, partStep;
   logic [7:0]        rowNum, parts, rowIdx, partIdx;
   logic [3:0]        kerCol, kerIdx;
   logic              jobEmpty, lastIssued;
   logic [1:0]        waitHold;

   logic              aguStart, groupStart, baseEndf, busy, done;
   logic [ADDR_W-1:0] baseAdder, inputCurCol;
   logic [1:0]        partFlag;
   logic [2:0]        lastColNum;

   logic              startAcc, issueFire, advance, finish;
   logic              kLast, pLast, rLast, lastGroup;
   logic [7:0]        partsCalc;
   logic [2:0]        lastColCalc;
   logic [ADDR_W-1:0] partStepCalc;

   always_comb begin
      partsCalc    = 8'((9'(bus.i_Output_XLength) + 9'(PE_COLS - 1)) / 9'(PE_COLS));
      lastColCalc  = 3'(PE_COLS);
      if (bus.i_Output_XLength != 8'd0)
         lastColCalc = 3'(bus.i_Output_XLength - 8'(PE_COLS) * (partsCalc - 8'd1));
      partStepCalc = ADDR_W'(bus.i_Stride) * ADDR_W'(PE_COLS);
   end

   assign kLast     = (kerIdx == kerCol - 4'd1);
   assign pLast     = (partIdx == parts - 8'd1);
   assign rLast     = (rowIdx == rowNum - 8'd1);
   assign lastGroup = kLast & pLast & rLast;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      startAcc  = 1'b0;
      issueFire = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_AGUStart) begin
               startAcc  = 1'b1;
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            if (jobEmpty) begin
               finish    = 1'b1;
               stateNext = IDLE;
            end else if (bus.i_FifoReady && bus.i_GroupLoadEnd) begin
               issueFire = 1'b1;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            // The AGU done level is stale until its launch has propagated.
            if (waitHold == 2'd0 && bus.i_GroupLoadEnd) begin
               if (lastIssued) begin
                  stateNext = DRAIN;
               end else begin
                  advance   = 1'b1;
                  stateNext = ISSUE;
               end
            end
         end
         DRAIN: begin
            if (bus.i_AGU_Endf) begin
               finish    = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rowPitch    <= '0;
         rowBase     <= '0;
         partCol     <= '0;
         partStep    <= '0;
         rowNum      <= '0;
         parts       <= '0;
         rowIdx      <= '0;
         partIdx     <= '0;
         kerCol      <= '0;
         kerIdx      <= '0;
         jobEmpty    <= 1'b0;
         lastIssued  <= 1'b0;
         waitHold    <= '0;
         aguStart    <= 1'b0;
         groupStart  <= 1'b0;
         baseEndf    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         baseAdder   <= '0;
         inputCurCol <= '0;
         partFlag    <= '0;
         lastColNum  <= 3'(PE_COLS);
      end else begin
         aguStart   <= startAcc;
         groupStart <= issueFire;
         done       <= finish;

         if (startAcc) begin
            rowPitch   <= bus.i_RowPitch;
            rowBase    <= bus.i_BaseAddr - ADDR_W'(bus.i_Pad);
            partCol    <= '0;
            partStep   <= partStepCalc;
            rowNum     <= bus.i_RowNum;
            parts      <= partsCalc;
            kerCol     <= bus.i_KerCol;
            rowIdx     <= '0;
            partIdx    <= '0;
            kerIdx     <= '0;
            jobEmpty   <= (bus.i_RowNum == 8'd0) || (bus.i_Output_XLength == 8'd0) ||
                          (bus.i_KerCol == 4'd0);
            lastIssued <= 1'b0;
            lastColNum <= lastColCalc;
            baseEndf   <= 1'b0;
            busy       <= 1'b1;
         end else if (state == IDLE) begin
            busy <= 1'b0;
         end

         if (issueFire) begin
            inputCurCol <= partCol + ADDR_W'(kerIdx);
            baseAdder   <= rowBase + partCol + ADDR_W'(kerIdx);
            partFlag    <= {partIdx == 8'd0, pLast};
            baseEndf    <= lastGroup;
            lastIssued  <= lastGroup;
            waitHold    <= 2'd2;
         end else if (waitHold != 2'd0) begin
            waitHold <= waitHold - 2'd1;
         end

         if (advance) begin
            if (!kLast) begin
               kerIdx <= kerIdx + 4'd1;
            end else begin
               kerIdx <= '0;
               if (!pLast) begin
                  partIdx <= partIdx + 8'd1;
                  partCol <= partCol + partStep;
               end else begin
                  partIdx <= '0;
                  partCol <= '0;
                  rowIdx  <= rowIdx + 8'd1;
                  rowBase <= rowBase + rowPitch;
               end
            end
         end

         if (finish) baseEndf <= 1'b0;
      end
   end

`ifdef IAGU_GSCHED_PERF_EN
   logic [19:0] groupCnt;
   logic [15:0] stallCnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || startAcc) begin
         groupCnt <= '0;
         stallCnt <= '0;
      end else begin
         if (issueFire) groupCnt <= groupCnt + 20'd1;
         if (state == ISSUE && !jobEmpty && !bus.i_FifoReady && stallCnt != 16'hFFFF)
            stallCnt <= stallCnt + 16'd1;
      end
   end

   assign bus.o_GroupCnt = groupCnt;
   assign bus.o_StallCnt = stallCnt;
`endif

   assign bus.o_AGUStart      = aguStart;
   assign bus.o_GroupStart    = groupStart;
   assign bus.o_BaseAdder     = baseAdder;
   assign bus.o_InputCurCol   = inputCurCol;
   assign bus.o_PartFlag      = partFlag;
   assign bus.o_LastColNum    = lastColNum;
   assign bus.o_BaseAdderEndf = baseEndf;
   assign bus.o_Busy          = busy;
   assign bus.o_Done          = done;
endmodule

// File: tb/tb_iagu_conv_gsched.sv
// Directed bench for iagu_conv_gsched; expected group lists are hand-computed.
module tb_iagu_conv_gsched;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iagu_conv_gsched_if #(.ADDR_W(ADDR_W)) bus ();

   iagu_conv_gsched #(.ADDR_W(ADDR_W), .PE_COLS(7)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   int errCnt = 0;
   int chkCnt = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W-1:0] colQ[$], baseQ[$], expCol[$], expBase[$];
   logic [1:0]        flagQ[$], expFlag[$];
   logic              endfQ[$], expEndf[$];
   int                grpCycQ[$];
   int                aguCnt = 0, aguCyc = 0, doneCnt = 0, doneCyc = 0;
   logic              busyAtDone = 1'b0;

   always @(negedge clk) begin
      if (bus.o_AGUStart) begin
         aguCnt = aguCnt + 1;
         aguCyc = cyc;
      end
      if (bus.o_GroupStart) begin
         colQ.push_back(bus.o_InputCurCol);
         baseQ.push_back(bus.o_BaseAdder);
         flagQ.push_back(bus.o_PartFlag);
         endfQ.push_back(bus.o_BaseAdderEndf);
         grpCycQ.push_back(cyc);
      end
      if (bus.o_Done) begin
         doneCnt    = doneCnt + 1;
         doneCyc    = cyc;
         busyAtDone = bus.o_Busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearLog();
      colQ.delete(); baseQ.delete(); flagQ.delete(); endfQ.delete(); grpCycQ.delete();
      expCol.delete(); expBase.delete(); expFlag.delete(); expEndf.delete();
   endtask

   task automatic addExp(input logic [ADDR_W-1:0] c, input logic [ADDR_W-1:0] b,
                         input logic [1:0] f, input logic e);
      expCol.push_back(c); expBase.push_back(b); expFlag.push_back(f); expEndf.push_back(e);
   endtask

   task automatic cmpGroups(input string name);
      chk({name, "_count"}, colQ.size(), expCol.size());
      for (int i = 0; i < expCol.size() && i < colQ.size(); i++) begin
         chk($sformatf("%s_col%0d", name, i),  colQ[i],  expCol[i]);
         chk($sformatf("%s_base%0d", name, i), baseQ[i], expBase[i]);
         chk($sformatf("%s_flag%0d", name, i), flagQ[i], expFlag[i]);
         chk($sformatf("%s_endf%0d", name, i), endfQ[i], expEndf[i]);
      end
   endtask

   task automatic startJob(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] pitch,
                           input logic [7:0] rows, input logic [7:0] xlen, input logic [3:0] ker,
                           input logic [1:0] stride, input logic [1:0] pad, output int sCyc);
      @(negedge clk);
      bus.i_BaseAddr       = base;
      bus.i_RowPitch       = pitch;
      bus.i_RowNum         = rows;
      bus.i_Output_XLength = xlen;
      bus.i_KerCol         = ker;
      bus.i_Stride         = stride;
      bus.i_Pad            = pad;
      bus.i_AGUStart       = 1'b1;
      sCyc                 = cyc;
      @(negedge clk);
      bus.i_AGUStart = 1'b0;
   endtask

   task automatic waitDone(input int prevDone, input int maxCyc);
      int n = 0;
      while (doneCnt == prevDone && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", doneCnt != prevDone, 1);
   endtask

   task automatic waitGroups(input int cnt, input int maxCyc);
      int n = 0;
      while (colQ.size() < cnt && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      chk("grp_reached", colQ.size() >= cnt, 1);
   endtask

   task automatic expReq021();
      addExp(12'h000, 12'h0FF, 2'b10, 1'b0);
      addExp(12'h001, 12'h100, 2'b10, 1'b0);
      addExp(12'h002, 12'h101, 2'b10, 1'b0);
      addExp(12'h007, 12'h106, 2'b01, 1'b0);
      addExp(12'h008, 12'h107, 2'b01, 1'b0);
      addExp(12'h009, 12'h108, 2'b01, 1'b1);
   endtask

   initial begin
      int s, prev, agu0;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, prev, agu0;
      bus.i_AGUStart = 0; bus.i_BaseAddr = 0; bus.i_RowPitch = 0; bus.i_RowNum = 0;
      bus.i_Output_XLength = 0; bus.i_KerCol = 0; bus.i_Stride = 0; bus.i_Pad = 0;
      bus.i_FifoReady = 1; bus.i_GroupLoadEnd = 1; bus.i_AGU_Endf = 1;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.o_Busy, 0);
      chk("rst_lastcol", bus.o_LastColNum, 7);
      chk("rst_grpstart", bus.o_GroupStart, 0);
      chk("rst_base", bus.o_BaseAdder, 0);
      chk("rst_flag", bus.o_PartFlag, 0);
      chk("rst_agustart", bus.o_AGUStart, 0);
      rst = 1'b0;
      @(negedge clk);

      // two parts, three kernel columns, pad 1
      clearLog(); expReq021(); prev = doneCnt;
      startJob(12'h100, 12'h040, 8'd1, 8'd14, 4'd3, 2'd1, 2'd1, s);
      waitDone(prev, 200);
      cmpGroups("r021");
      chk("r021_agucyc", aguCyc, s + 1);
      if (grpCycQ.size() >= 2) begin
         chk("r021_grp0cyc", grpCycQ[0], s + 2);
         chk("r021_grp1cyc", grpCycQ[1], s + 6);
      end
      chk("r021_donecyc", doneCyc, s + 26);
      chk("r021_busydone", busyAtDone, 1);
      chk("r021_lastcol", bus.o_LastColNum, 7);
      @(negedge clk);
      chk("r021_busyafter", bus.o_Busy, 0);
      chk("r021_endfafter", bus.o_BaseAdderEndf, 0);
`ifdef IAGU_GSCHED_PERF_EN
      chk("r021_grpcnt", bus.o_GroupCnt, 6);
      chk("r021_stallcnt", bus.o_StallCnt, 0);
`endif

      // single part over two rows; done held off by the AGU end flag
      clearLog(); prev = doneCnt;
      addExp(12'h000, 12'h1FE, 2'b11, 1'b0);
      addExp(12'h000, 12'h21E, 2'b11, 1'b1);
      bus.i_AGU_Endf = 1'b0;
      startJob(12'h200, 12'h020, 8'd2, 8'd5, 4'd1, 2'd2, 2'd2, s);
      repeat (14) @(negedge clk);
      chk("r022_nodone", doneCnt, prev);
      chk("r022_endfhold", bus.o_BaseAdderEndf, 1);
      chk("r022_busyhold", bus.o_Busy, 1);
      bus.i_AGU_Endf = 1'b1;
      waitDone(prev, 50);
      cmpGroups("r022");
      chk("r022_lastcol", bus.o_LastColNum, 5);

      // stride 2 part step with address wrap below zero
      clearLog(); prev = doneCnt;
      addExp(12'h000, 12'hFFD, 2'b10, 1'b0);
      addExp(12'h001, 12'hFFE, 2'b10, 1'b0);
      addExp(12'h00E, 12'h00B, 2'b01, 1'b0);
      addExp(12'h00F, 12'h00C, 2'b01, 1'b1);
      startJob(12'h000, 12'h040, 8'd1, 8'd8, 4'd2, 2'd2, 2'd3, s);
      waitDone(prev, 100);
      cmpGroups("wrap");
      chk("wrap_lastcol", bus.o_LastColNum, 1);

      // FIFO not ready for ten ISSUE cycles
      clearLog(); prev = doneCnt;
      addExp(12'h000, 12'h300, 2'b11, 1'b1);
      bus.i_FifoReady = 1'b0;
      startJob(12'h300, 12'h000, 8'd1, 8'd1, 4'd1, 2'd1, 2'd0, s);
      repeat (10) @(negedge clk);
      chk("stall_nogrp", colQ.size(), 0);
      bus.i_FifoReady = 1'b1;
      waitDone(prev, 50);
      cmpGroups("stall");
      if (grpCycQ.size() >= 1) chk("stall_grpcyc", grpCycQ[0], s + 12);
`ifdef IAGU_GSCHED_PERF_EN
      chk("stall_stallcnt", bus.o_StallCnt, 10);
      chk("stall_grpcnt", bus.o_GroupCnt, 1);
`endif

      // degenerate jobs: zero output length, then zero kernel columns
      clearLog(); prev = doneCnt;
      startJob(12'h100, 12'h010, 8'd2, 8'd0, 4'd3, 2'd1, 2'd0, s);
      chk("empty_busy", bus.o_Busy, 1);
      waitDone(prev, 20);
      chk("empty_agucyc", aguCyc, s + 1);
      chk("empty_donecyc", doneCyc, s + 2);
      chk("empty_busydone", busyAtDone, 1);
      chk("empty_nogrp", colQ.size(), 0);
      prev = doneCnt;
      startJob(12'h100, 12'h010, 8'd1, 8'd4, 4'd0, 2'd1, 2'd0, s);
      waitDone(prev, 20);
      chk("noker_donecyc", doneCyc, s + 2);
      chk("noker_nogrp", colQ.size(), 0);

      // reset after the third group, then rerun from group 0
      clearLog(); prev = doneCnt;
      startJob(12'h100, 12'h040, 8'd1, 8'd14, 4'd3, 2'd1, 2'd1, s);
      waitGroups(3, 100);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy", bus.o_Busy, 0);
      chk("mrst_grpstart", bus.o_GroupStart, 0);
      chk("mrst_base", bus.o_BaseAdder, 0);
      chk("mrst_col", bus.o_InputCurCol, 0);
      chk("mrst_flag", bus.o_PartFlag, 0);
      chk("mrst_lastcol", bus.o_LastColNum, 7);
      chk("mrst_endf", bus.o_BaseAdderEndf, 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("mrst_nodone", doneCnt, prev);
      clearLog(); expReq021(); prev = doneCnt;
      startJob(12'h100, 12'h040, 8'd1, 8'd14, 4'd3, 2'd1, 2'd1, s);
      waitDone(prev, 200);
      cmpGroups("rerun");

      // start pulse during WAIT is ignored
      clearLog(); expReq021(); prev = doneCnt; agu0 = aguCnt;
      startJob(12'h100, 12'h040, 8'd1, 8'd14, 4'd3, 2'd1, 2'd1, s);
      waitGroups(1, 50);
      @(negedge clk);
      bus.i_AGUStart = 1'b1;
      @(negedge clk);
      bus.i_AGUStart = 1'b0;
      waitDone(prev, 200);
      cmpGroups("ign");
      chk("ign_agucnt", aguCnt - agu0, 1);
      chk("ign_donecyc", doneCyc, s + 26);
      repeat (10) @(negedge clk);
      chk("ign_donecnt", doneCnt - prev, 1);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule
